alu_arbiter: RTL

Two-requester controller that shares the single 4-bit `alu` datapath between two independent clients. It accepts one operation at a time via a valid/ready handshake and arbitrates round-robin. It latches the operands, runs them through the `alu` instance, and returns the result on a shared response channel with backpressure. It sits between the client front-ends and the `alu`, and is the only driver of the `alu`'s `a`/`b`/`cin`/`sel` inputs.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 33 +++
 rtl/rr_arb2.sv | 13 +
 rtl/alu_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and controller state encoding for the alu_arbiter slice.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_NOR = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_NOT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU; carry-out is only meaningful for ADD.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (sel)
            ALU_ADD: {cout, result} = sum;
            ALU_AND: result = a & b;
            ALU_NOR: result = ~(a | b);
            ALU_OR:  result = a | b;
            ALU_NOT: result = ~a;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester other than last_id wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_id,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = valid0 & (~valid1 | last_id);
    assign gnt1 = valid1 & (~valid0 | ~last_id);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between two requesters: round-robin accept, one-cycle execute,
// response held until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    input  logic [2:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             busy,
    output logic [7:0]       done_count
);

    state_t           state;
    logic             last_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [2:0]       op_sel;
    logic             op_id;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;

    rr_arb2 u_arb (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .last_id (last_id),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .cin    (op_cin),
        .sel    (op_sel),
        .result (alu_result),
        .cout   (alu_cout)
    );

    // Accept only in IDLE; a valid seen while leaving RESP waits for the next IDLE cycle.
    assign req0_ready = (state == IDLE) & gnt0;
    assign req1_ready = (state == IDLE) & gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_id    <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_sel     <= '0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            busy       <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        op_a   <= gnt1 ? req1_a : req0_a;
                        op_b   <= gnt1 ? req1_b : req0_b;
                        op_cin <= gnt1 ? req1_cin : req0_cin;
                        op_sel <= gnt1 ? req1_sel : req0_sel;
                        op_id  <= gnt1;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_cout   <= alu_cout;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        busy       <= 1'b0;
                        done_count <= done_count + 8'd1;
                        last_id    <= rsp_id;
                        state      <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
